// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared state encodings, lane constants and address check for dmem_responder
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam int BYTE_W          = 8;
    localparam int LANES           = 4;
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_WAIT_CYCLES = 2;

    // Misaligned, below the base, or past the last word of a 2**addr_w array.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned addr_w);
        logic [31:0] word_idx;
        word_idx = (addr - base) >> 2;
        return (addr[1:0] != 2'b00) || (addr < base) || ((word_idx >> addr_w) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with byte-enabled synchronous write and combinational read
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [LANES-1:0]  be,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Write only the enabled byte lanes; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder in front of dmem_array
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          ADDR_W      = DEF_ADDR_W,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    dmem_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_be;

    logic              lat_err;
    logic              commit;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [31:0]       arr_rdata;

    // The commit happens on the WAIT edge where the counter is already zero.
    // With WAIT_CYCLES=0 WAIT therefore lasts exactly one commit cycle,
    // giving the one-cycle acceptance-to-response latency.
    assign lat_err  = addr_err(lat_addr, BASE_ADDR, ADDR_W);
    assign commit   = (state == ST_WAIT) && (cnt == '0);
    assign arr_we   = commit && lat_we && !lat_err;
    assign arr_addr = ADDR_W'((lat_addr - BASE_ADDR) >> 2);

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (lat_wdata),
        .be    (lat_be),
        .rdata (arr_rdata)
    );

    // Request/response FSM with registered handshake outputs and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_be     <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        cnt       <= CNT_W'(WAIT_CYCLES);
                        req_ready <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= lat_err;
                        resp_rdata <= (!lat_err && !lat_we) ? arr_rdata : 32'h0;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'h0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
